// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then shift a start bit, 8 data bits,
// odd parity and stop on device clock edges, and finally sample the device acknowledge.
module ps2_tx #(
    parameter int RTS_CYCLES     = 12000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2c,
    input  logic       i_ps2d,
    input  logic       i_wr_ps2,
    input  logic [7:0] i_din,
    output logic       o_ps2c_oe,
    output logic       o_ps2d_oe,
    output logic       o_tx_idle,
    output logic       o_tx_done_tick,
    output logic       o_ack_err,
    output logic       o_timeout_err
);

    localparam int RW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RTS,
        S_START,
        S_DATA,
        S_STOP,
        S_ACK
    } state_t;

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_c;
    logic                  filt_c_prev;
    logic                  fall;

    state_t                state, state_n;
    logic [8:0]            frame, frame_n;
    logic [3:0]            idx, idx_n;
    logic [RW-1:0]         rts_cnt, rts_cnt_n;
    logic [WW-1:0]         wd_cnt, wd_cnt_n;
    logic                  ack_err, ack_err_n;
    logic                  timeout_err, timeout_err_n;
    logic                  done_q, done_n;
    logic                  wd_hit;

    // Both lines idle high, so conditioning state resets to 1 to avoid a phantom edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            c_sync      <= 2'b11;
            d_sync      <= 2'b11;
            filt_sr     <= '1;
            filt_c      <= 1'b1;
            filt_c_prev <= 1'b1;
        end else begin
            c_sync      <= {c_sync[0], i_ps2c};
            d_sync      <= {d_sync[0], i_ps2d};
            filt_sr     <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
            filt_c_prev <= filt_c;
            if (&filt_sr)
                filt_c <= 1'b1;
            else if (~|filt_sr)
                filt_c <= 1'b0;
        end
    end

    assign fall   = filt_c_prev & ~filt_c;
    assign wd_hit = (wd_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            frame       <= '0;
            idx         <= '0;
            rts_cnt     <= '0;
            wd_cnt      <= '0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_n;
            frame       <= frame_n;
            idx         <= idx_n;
            rts_cnt     <= rts_cnt_n;
            wd_cnt      <= wd_cnt_n;
            ack_err     <= ack_err_n;
            timeout_err <= timeout_err_n;
            done_q      <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        frame_n       = frame;
        idx_n         = idx;
        rts_cnt_n     = rts_cnt;
        wd_cnt_n      = wd_cnt;
        ack_err_n     = ack_err;
        timeout_err_n = timeout_err;
        done_n        = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_wr_ps2) begin
                    frame_n       = {~^i_din, i_din};
                    ack_err_n     = 1'b0;
                    timeout_err_n = 1'b0;
                    rts_cnt_n     = RW'(RTS_CYCLES - 1);
                    state_n       = S_RTS;
                end
            end
            S_RTS: begin
                if (rts_cnt == '0) begin
                    wd_cnt_n = '0;
                    state_n  = S_START;
                end else begin
                    rts_cnt_n = rts_cnt - 1'b1;
                end
            end
            default: begin
                // Device-clocked phase: the watchdog restarts on every filtered falling edge.
                if (fall) begin
                    wd_cnt_n = '0;
                    case (state)
                        S_START: begin
                            idx_n   = '0;
                            state_n = S_DATA;
                        end
                        S_DATA: begin
                            if (idx == 4'd8) begin
                                state_n = S_STOP;
                            end else begin
                                frame_n = {1'b0, frame[8:1]};
                                idx_n   = idx + 4'd1;
                            end
                        end
                        S_STOP: state_n = S_ACK;
                        S_ACK: begin
                            ack_err_n = d_sync[1];
                            done_n    = 1'b1;
                            state_n   = S_IDLE;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end else if (wd_hit) begin
                    timeout_err_n = 1'b1;
                    done_n        = 1'b1;
                    state_n       = S_IDLE;
                end else begin
                    wd_cnt_n = wd_cnt + 1'b1;
                end
            end
        endcase
    end

    assign o_ps2c_oe      = (state == S_RTS);
    assign o_ps2d_oe      = (state == S_START) || ((state == S_DATA) && !frame[0]);
    assign o_tx_idle      = (state == S_IDLE);
    assign o_tx_done_tick = done_q;
    assign o_ack_err      = ack_err;
    assign o_timeout_err  = timeout_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: an open-drain line model plus a clocking device that samples bits on
// rising edges and compares them against the frame computed from the command byte.
module tb_ps2_tx;
    localparam int RTS  = 20;
    localparam int FL   = 4;
    localparam int TO   = 500;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    logic       c_oe, d_oe, idle, done, ack_err, to_err;
    logic       ps2c, ps2d;

    assign ps2c = ~(c_oe | dev_c_low);
    assign ps2d = ~(d_oe | dev_d_low);

    ps2_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(reset), .i_ps2c(ps2c), .i_ps2d(ps2d),
        .i_wr_ps2(wr), .i_din(din),
        .o_ps2c_oe(c_oe), .o_ps2d_oe(d_oe), .o_tx_idle(idle),
        .o_tx_done_tick(done), .o_ack_err(ack_err), .o_timeout_err(to_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame as it must appear on the wire, LSB first: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic p;
        p = 1'b1;
        for (int i = 0; i < 8; i++) p = p ^ b[i];
        return {1'b1, p, b};
    endfunction

    int   rts_run = 0;
    int   last_rts = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (idle) check("idle_lines_released", 32'({c_oe, d_oe}), 32'd0);
            if (c_oe) check("rts_data_released", 32'(d_oe), 32'd0);
            if (done) begin
                check("done_one_cycle", 32'(done_prev), 32'd0);
                done_cnt++;
            end
        end
        if (c_oe) rts_run++;
        else if (rts_run != 0) begin
            last_rts = rts_run;
            rts_run  = 0;
        end
        done_prev = done;
    end

    task automatic send(input logic [7:0] b, input bit ack_low, input int stop_after,
                        input int inject_at, input int glitch_at, input int reset_at,
                        output logic [9:0] seen);
        logic [9:0] exp;
        int         d0, since, nbits;
        bit         got, aborted;
        exp     = model_frame(b);
        seen    = '0;
        d0      = done_cnt;
        aborted = 1'b0;
        nbits   = 10;
        wr = 1'b1; din = b; tick(); wr = 1'b0;
        tick();
        check("errs_cleared", 32'({ack_err, to_err}), 32'd0);
        check("busy_after_write", 32'(idle), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (!c_oe && d_oe) got = 1'b1;
        end
        check("start_reached", 32'(got), 32'd1);
        repeat (5) tick();
        check("rts_length", 32'(last_rts), 32'(RTS));
        check("start_bit_low", 32'(ps2d), 32'd0);

        for (int p = 1; p <= stop_after && p <= 14 && done_cnt == d0 && !aborted; p++) begin
            dev_c_low = 1'b1;
            for (int k = 0; k < HALF && !aborted; k++) begin
                wr = (p == inject_at && k == 10);
                din = (p == inject_at) ? 8'h55 : b;
                if (p == reset_at && k == 10) begin
                    reset = 1'b1;
                    tick();
                    check("reset_lines_released", 32'({c_oe, d_oe}), 32'd0);
                    reset = 1'b0;
                    aborted = 1'b1;
                    nbits = p - 1;
                end else begin
                    tick();
                end
            end
            wr = 1'b0;
            if (!aborted) begin
                if (p <= 10) seen[p-1] = ps2d;
                dev_c_low = 1'b0;
                if (p == 10) dev_d_low = ack_low;
                for (int k = 0; k < HALF; k++) begin
                    if (p == glitch_at && k == 8) dev_c_low = 1'b1;
                    if (p == glitch_at && k == 10) dev_c_low = 1'b0;
                    tick();
                end
            end
        end
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        if (stop_after < nbits) nbits = stop_after;
        for (int i = 0; i < nbits; i++)
            check($sformatf("bit%0d_of_%02h", i, b), 32'(seen[i]), 32'(exp[i]));

        if (aborted) begin
            repeat (60) tick();
            check("reset_no_done", 32'(done_cnt - d0), 32'd0);
            check("reset_idle", 32'(idle), 32'd1);
            check("reset_errs", 32'({ack_err, to_err}), 32'd0);
        end else if (stop_after < 12) begin
            since = 2 * HALF;
            got = 1'b0;
            for (int i = 0; i < 700 && !got; i++) begin
                tick();
                since++;
                if (done) got = 1'b1;
            end
            check("timeout_fired", 32'(got), 32'd1);
            check("timeout_not_early", 32'(since >= TO), 32'd1);
            check("timeout_not_late", 32'(since <= TO + 30), 32'd1);
            check("timeout_lines", 32'({c_oe, d_oe}), 32'd0);
            check("timeout_err", 32'(to_err), 32'd1);
            check("timeout_ack_err", 32'(ack_err), 32'd0);
            tick();
            check("timeout_idle", 32'(idle), 32'd1);
            check("timeout_done_count", 32'(done_cnt - d0), 32'd1);
        end else begin
            repeat (4) tick();
            check("done_count", 32'(done_cnt - d0), 32'd1);
            check("ack_err", 32'(ack_err), 32'(!ack_low));
            check("timeout_err_clear", 32'(to_err), 32'd0);
            check("idle_after_frame", 32'(idle), 32'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "time limit");
    end

    initial begin
        logic [9:0] seen;
        int         dc;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_idle", 32'(idle), 32'd1);
        check("reset_oe", 32'({c_oe, d_oe}), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_errs", 32'({ack_err, to_err}), 32'd0);
        repeat (10) tick();
        check("quiet_oe", 32'({c_oe, d_oe}), 32'd0);
        check("quiet_idle", 32'(idle), 32'd1);

        check("model_frame_ed", 32'(model_frame(8'hED)), 32'h3ED);
        check("model_frame_f4", 32'(model_frame(8'hF4)), 32'h2F4);

        send(8'hED, 1'b1, 99, 0, 0, 0, seen);
        check("ed_wire_literal", 32'(seen), 32'h3ED);

        send(8'h00, 1'b0, 99, 0, 0, 0, seen);
        check("00_wire_literal", 32'(seen), 32'h300);
        check("ack_err_sticky", 32'(ack_err), 32'd1);

        send(8'hFF, 1'b1, 3, 0, 0, 0, seen);
        check("ff_first_bits", 32'(seen[2:0]), 32'h7);

        send(8'hF4, 1'b1, 99, 4, 0, 0, seen);
        check("f4_wire_literal", 32'(seen), 32'h2F4);
        dc = done_cnt;
        repeat (60) tick();
        check("ignored_write_no_frame", 32'({idle, c_oe, d_oe}), 32'h4);
        check("ignored_write_no_done", 32'(done_cnt - dc), 32'd0);

        send(8'h3C, 1'b1, 99, 0, 3, 0, seen);
        check("glitch_wire_literal", 32'(seen), 32'h33C);

        send(8'h3C, 1'b1, 99, 0, 0, 6, seen);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
